// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared types and helpers for the BCD countdown timer
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational single-digit BCD decrement with borrow chain
module bcd_digit_dec
    import bcd_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        if (borrow_in) begin
            digit_next = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD down-counter with load, start/stop and terminal count
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  zero,
    output logic                  done,
    output logic                  load_err
);

    localparam int CW = 4 * DIGITS;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   reload_q, reload_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            load_err_q, load_err_d;

    logic            dec_en;
    logic            load_ok;
    logic [CW-1:0]   count_dec;
    logic [DIGITS:0] borrow;

    assign dec_en    = (state_q == RUN) && tick;
    assign borrow[0] = dec_en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit      (count_q[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .digit_next (count_dec[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // A load request, valid or not, takes priority over start.
                if (load) begin
                    if (load_ok) begin
                        count_d  = load_val;
                        reload_d = load_val;
                        state_d  = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start) begin
                    if (state_q == IDLE) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end
                    end else if (reload_q != '0) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Final borrow out of the top digit would mean underflow; never let it wrap.
                if (dec_en && !borrow[DIGITS]) begin
                    count_d = count_dec;
                end
                if (tick && count_q == CW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (stop) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign zero     = (count_q == '0);
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    localparam int DIGITS = 2;
    localparam int CW     = 4 * DIGITS;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tick = 1'b0;
    logic [CW-1:0] count;
    logic          running, zero, done, load_err;

    typedef struct {
        logic [CW-1:0] count;
        logic          running;
        logic          zero;
        logic          done;
        logic          load_err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int m_state = M_IDLE;
    int m_cnt   = 0;
    int m_rel   = 0;

    bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .count    (count),
        .running  (running),
        .zero     (zero),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [CW-1:0] b);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic bit all_digits_ok(input logic [CW-1:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [CW-1:0] v,
                        input logic s, input logic p, input logic t);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; load = l; load_val = v; start = s; stop = p; tick = t;
        e.done = 1'b0;
        e.load_err = 1'b0;
        if (r) begin
            m_state = M_IDLE; m_cnt = 0; m_rel = 0;
        end else begin
            case (m_state)
                M_IDLE, M_DONE: begin
                    if (l) begin
                        if (all_digits_ok(v)) begin
                            m_cnt = from_bcd(v); m_rel = m_cnt; m_state = M_IDLE;
                        end else begin
                            e.load_err = 1'b1;
                        end
                    end else if (s) begin
                        if (m_state == M_IDLE && m_cnt > 0) begin
                            m_state = M_RUN;
                        end else if (m_state == M_DONE && m_rel > 0) begin
                            m_cnt = m_rel; m_state = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (t) m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_state = M_DONE; e.done = 1'b1;
                    end else if (p) begin
                        m_state = M_HOLD;
                    end
                end
                default: begin
                    if (s && !p) m_state = M_RUN;
                end
            endcase
        end
        e.count   = to_bcd(m_cnt);
        e.running = (m_state == M_RUN);
        e.zero    = (m_cnt == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",    32'(count),    32'(e.count));
                check("running",  32'(running),  32'(e.running));
                check("zero",     32'(zero),     32'(e.zero));
                check("done",     32'(done),     32'(e.done));
                check("load_err", 32'(load_err), 32'(e.load_err));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : driver
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        idle(2);

        step(0, 1, 8'h12, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        ticks(12);
        ticks(3);

        step(0, 1, 8'h1A, 0, 0, 0);
        idle(1);
        step(0, 1, 8'h23, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 1, 8'h45, 0, 0, 1);
        idle(1);

        step(1, 0, '0, 0, 0, 0);
        step(0, 1, 8'h06, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        ticks(1);
        step(0, 0, '0, 0, 1, 1);
        ticks(3);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 0, 0);
        ticks(1);
        ticks(3);

        step(1, 0, '0, 0, 0, 0);
        step(0, 1, 8'h12, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        ticks(12);
        step(0, 0, '0, 1, 0, 0);
        ticks(12);
        step(0, 1, 8'h00, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 1, 8'h07, 1, 0, 0);
        idle(1);

        step(0, 1, 8'h37, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(1, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 0, 0);
        idle(1);

        for (int n = 0; n < 2500; n++) begin
            logic r, l, s, p, t;
            logic [CW-1:0] v;
            r = ($urandom_range(0, 299) == 0);
            l = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 3) == 0) ? CW'($urandom) : to_bcd($urandom_range(0, 20));
            s = ($urandom_range(0, 4) == 0);
            p = ($urandom_range(0, 9) == 0);
            t = 1'($urandom_range(0, 1));
            step(r, l, v, s, p, t);
        end

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with load, start/stop control and terminal-count detection. It is the count-down complement of the team's modulo-10 up-counter. It counts an externally supplied tick strobe down from a loaded BCD value to zero, flags completion, and supports restart from the last loaded value. It is used for timeouts, countdown displays and delay generation alongside the BCD up-counters.

## Interface
Parameters:
- DIGITS, default 2: number of BCD digits; count width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  load request; load_val sampled this cycle
- load_val  input  4*DIGITS  BCD value to load; digit 0 occupies [3:0]
- start  input  1  start or resume counting
- stop  input  1  pause counting
- tick  input  1  one-cycle count-enable strobe
- count  output  4*DIGITS  current BCD count (registered)
- running  output  1  state == RUN (registered)
- zero  output  1  count == 0 (decoded from the count register)
- done  output  1  one-cycle pulse when count reaches 0 from RUN
- load_err  output  1  one-cycle pulse when a load is rejected

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset values: state IDLE, count 0, reload register 0, running 0, zero 1, done 0, load_err 0.
- **Load** is accepted only in IDLE or DONE.
  - Valid load (every nibble ≤ 9): count and reload register take load_val. State becomes IDLE.
  - Invalid load (any nibble > 9): count, reload register and state are unchanged. load_err is 1 the next cycle.
  - load in RUN or HOLD is ignored, with no load_err.
- **IDLE**:
  - start with count != 0 → RUN.
  - start with count == 0 is ignored.
  - load and start in the same cycle: load wins and start is dropped.
- **RUN**:
  - Each tick decrements count by 1 in BCD: a digit at 0 becomes 9 and borrows from the next digit; a digit at non-zero decrements by 1.
  - A tick at count == 1 makes count 0, sets state to DONE and pulses done for one cycle.
  - stop → HOLD. If tick is also high that cycle, the decrement is applied as well.
  - start in RUN has no effect.
- **HOLD**:
  - tick is ignored.
  - start → RUN.
  - start and stop in the same cycle: stop wins and the state stays HOLD.
- **DONE**:
  - count holds 0 and zero is 1.
  - start reloads count from the reload register and enters RUN. If the reload register is 0, it stays DONE.
  - A valid load → IDLE.
- Count never underflows. Count 0 is reached only via the DONE transition, and tick is ignored outside RUN.
- Simultaneous start and stop in any state: stop wins where it applies (RUN or HOLD); otherwise start rules apply.

## Timing
- Inputs are sampled on the rising clk edge. count, running, done and load_err update at that edge and are visible the following cycle.
- done and count == 0 become visible in the same cycle. done is high for exactly one cycle.
- Latency from load to count update: 1 cycle. From start to running: 1 cycle. From tick to count update: 1 cycle.
- Back-to-back ticks on consecutive cycles are supported; every tick in RUN counts.
- rst is synchronous. Asserting it in any state forces all reset values at the next edge and overrides load, start, stop and tick.
- zero is combinational from the count register only; there is no input-to-output combinational path.

## Structure
- Package bcd_timer_pkg contains:
  - the state enum typedef (IDLE, RUN, HOLD, DONE)
  - BCD_MAX = 4'd9
  - a function that validates a single nibble as BCD.
- Sub-module bcd_digit_dec is purely combinational:
  - inputs: digit[3:0], borrow_in
  - outputs: digit_next[3:0], borrow_out
  - borrow_out = borrow_in & (digit == 0).
  - The top level chains DIGITS instances by generate loop. Digit 0's borrow_in is the decrement enable.
- The top level holds the FSM, the count register, the reload register and the pulse registers.

## Test plan
- Reset: hold rst high for 2 cycles → count 8'h00, zero 1, running 0, done 0, load_err 0.
- Full countdown: load 8'h12 in IDLE, then start, then 12 ticks → count 11, 10, 09, …, 01, 00. 10 → 09 shows the borrow. done pulses once with count 00, state ends in DONE, no further change.
- Invalid load: load 8'h1A in IDLE → load_err pulses 1 cycle and count is unchanged. load 8'h45 while in RUN → ignored, no load_err.
- Pause: in RUN at 8'h05, assert stop and tick together → count 04, state HOLD. 3 ticks → still 04. start → RUN, next tick gives 03.
- Restart: in DONE after loading 8'h12, assert start → count 12, running 1 the next cycle. load 8'h00 followed by start in IDLE → start ignored, stays IDLE.
- Mid-run reset: in RUN at 8'h37, assert rst together with tick → next cycle count 00, IDLE, reload register 0. A subsequent start in DONE or IDLE has no effect.
